// File: rtl/car_bank.sv
// rtl/car_bank.sv - parametrised counter/address register bank
// Registers load from the transfer bus, count up/down, and drive two selected read ports; logical 0/1 may be swapped.
module car_bank #(
   parameter int WIDTH       = 16,
   parameter int NUM_REGS    = 5,
   parameter int SEL_W       = 3,
   parameter int RESET_VALUE = 0,
   parameter int HAS_FLIP    = 1
) (
   input  logic                MAINCLK,
   input  logic                MAINRST,
   input  logic [WIDTH-1:0]    xfer_in,
   input  logic [SEL_W-1:0]    load_sel,
   input  logic [NUM_REGS-1:0] inc_vec,
   input  logic [NUM_REGS-1:0] dec_vec,
   input  logic [SEL_W-1:0]    addr_sel,
   input  logic [SEL_W-1:0]    xfer_sel,
   input  logic                pcra_flip,
   output logic [WIDTH-1:0]    addr_out,
   output logic                addr_valid,
   output logic [WIDTH-1:0]    xfer_out,
   output logic                xfer_valid,
   output logic                flip_state,
   output logic [NUM_REGS-1:0] wrap_pulse
);

   localparam int   IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic FLIP_EN = (HAS_FLIP != 0);

   logic [WIDTH-1:0]    regs_q [NUM_REGS];
   logic [WIDTH-1:0]    regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] wrap_q, wrap_d;
   logic                flip_q, flip_d;

   // Logical-to-physical index; the swap is its own inverse.
   function automatic logic [IDX_W-1:0] map_idx(input logic [IDX_W-1:0] idx, input logic flip);
      if (FLIP_EN && flip && (idx < IDX_W'(2)))
         return idx ^ IDX_W'(1);
      return idx;
   endfunction

   always_comb begin
      logic [IDX_W-1:0] p;
      flip_d = flip_q ^ (pcra_flip & FLIP_EN);
      wrap_d = '0;
      for (int n = 0; n < NUM_REGS; n++) regs_d[n] = regs_q[n];
      for (int l = 0; l < NUM_REGS; l++) begin
         p = map_idx(IDX_W'(l), flip_q);
         if (load_sel == SEL_W'(l + 1)) begin
            regs_d[p] = xfer_in;
         end else if (inc_vec[l] && !dec_vec[l]) begin
            regs_d[p] = regs_q[p] + WIDTH'(1);
            wrap_d[l] = &regs_q[p];
         end else if (dec_vec[l] && !inc_vec[l]) begin
            regs_d[p] = regs_q[p] - WIDTH'(1);
            wrap_d[l] = ~|regs_q[p];
         end
      end
   end

   always_ff @(posedge MAINCLK or negedge MAINRST) begin
      if (!MAINRST) begin
         for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= WIDTH'(RESET_VALUE);
         wrap_q <= '0;
         flip_q <= 1'b0;
      end else begin
         for (int n = 0; n < NUM_REGS; n++) regs_q[n] <= regs_d[n];
         wrap_q <= wrap_d;
         flip_q <= flip_d;
      end
   end

   always_comb begin
      logic [IDX_W-1:0] a_idx, x_idx;
      addr_valid = (addr_sel != '0) && (int'(addr_sel) <= NUM_REGS);
      xfer_valid = (xfer_sel != '0) && (int'(xfer_sel) <= NUM_REGS);
      a_idx      = map_idx(IDX_W'(int'(addr_sel) - 1), flip_q);
      x_idx      = map_idx(IDX_W'(int'(xfer_sel) - 1), flip_q);
      addr_out   = addr_valid ? regs_q[a_idx] : '0;
      xfer_out   = xfer_valid ? regs_q[x_idx] : '0;
   end

   assign flip_state = flip_q;
   assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_car_bank.sv
// tb/tb_car_bank.sv - scoreboard bench for car_bank
// Driver pushes expected outputs from a logical-register model; monitor pops and compares each cycle.
module tb_car_bank;

   logic        MAINCLK;
   logic        MAINRST;
   logic [15:0] xfer_in;
   logic [2:0]  load_sel;
   logic [4:0]  inc_vec, dec_vec;
   logic [2:0]  addr_sel, xfer_sel;
   logic        pcra_flip;
   logic [15:0] addr_out, xfer_out;
   logic        addr_valid, xfer_valid, flip_state;
   logic [4:0]  wrap_pulse;

   car_bank dut (
      .MAINCLK(MAINCLK), .MAINRST(MAINRST), .xfer_in(xfer_in), .load_sel(load_sel),
      .inc_vec(inc_vec), .dec_vec(dec_vec), .addr_sel(addr_sel), .xfer_sel(xfer_sel),
      .pcra_flip(pcra_flip), .addr_out(addr_out), .addr_valid(addr_valid),
      .xfer_out(xfer_out), .xfer_valid(xfer_valid), .flip_state(flip_state),
      .wrap_pulse(wrap_pulse)
   );

   initial MAINCLK = 1'b0;
   always #5 MAINCLK = ~MAINCLK;

   typedef struct {
      logic        av;
      logic [15:0] ao;
      logic        xv;
      logic [15:0] xo;
      logic        fs;
      logic [4:0]  wp;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference state: physical register contents and current mapping.
   int   m_reg[5];
   int   m_flip;
   logic [4:0] m_wrap;

   function automatic int phys(input int l);
      return (m_flip == 1 && l < 2) ? 1 - l : l;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 5; i++) m_reg[i] = 0;
      m_flip = 0;
      m_wrap = '0;
   endfunction

   function automatic void model_edge(input int xi, input int ls, input logic [4:0] iv,
                                      input logic [4:0] dv, input logic pf);
      int nr[5];
      for (int i = 0; i < 5; i++) nr[i] = m_reg[i];
      m_wrap = '0;
      for (int l = 0; l < 5; l++) begin
         int p = phys(l);
         if (ls == l + 1) nr[p] = xi;
         else if (iv[l] && !dv[l]) begin
            if (m_reg[p] == 65535) m_wrap[l] = 1'b1;
            nr[p] = (m_reg[p] + 1) % 65536;
         end else if (dv[l] && !iv[l]) begin
            if (m_reg[p] == 0) m_wrap[l] = 1'b1;
            nr[p] = (m_reg[p] + 65535) % 65536;
         end
      end
      for (int i = 0; i < 5; i++) m_reg[i] = nr[i];
      if (pf) m_flip = 1 - m_flip;
   endfunction

   function automatic exp_t model_out(input int as, input int xs);
      exp_t e;
      e.av = (as >= 1 && as <= 5);
      e.xv = (xs >= 1 && xs <= 5);
      e.ao = e.av ? 16'(m_reg[phys(as - 1)]) : 16'h0;
      e.xo = e.xv ? 16'(m_reg[phys(xs - 1)]) : 16'h0;
      e.fs = (m_flip == 1);
      e.wp = m_wrap;
      return e;
   endfunction

   task automatic step(input logic rst, input logic [15:0] xi, input logic [2:0] ls,
                       input logic [4:0] iv, input logic [4:0] dv, input logic [2:0] as,
                       input logic [2:0] xs, input logic pf);
      @(negedge MAINCLK);
      MAINRST = rst; xfer_in = xi; load_sel = ls; inc_vec = iv; dec_vec = dv;
      addr_sel = as; xfer_sel = xs; pcra_flip = pf;
      if (!rst) model_reset();
      exp_q.push_back(model_out(int'(as), int'(xs)));
      if (rst) model_edge(int'(xi), int'(ls), iv, dv, pf);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge MAINCLK);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("addr_valid", 32'(addr_valid), 32'(e.av));
            chk("addr_out",   32'(addr_out),   32'(e.ao));
            chk("xfer_valid", 32'(xfer_valid), 32'(e.xv));
            chk("xfer_out",   32'(xfer_out),   32'(e.xo));
            chk("flip_state", 32'(flip_state), 32'(e.fs));
            chk("wrap_pulse", 32'(wrap_pulse), 32'(e.wp));
         end
      end
   end

   initial begin
      logic [15:0] xi;
      int          waited;
      MAINRST = 1'b0; xfer_in = '0; load_sel = '0; inc_vec = '0; dec_vec = '0;
      addr_sel = '0; xfer_sel = '0; pcra_flip = 1'b0;
      model_reset();

      // Held load during reset must not take effect.
      step(0, 16'hBEEF, 1, 0, 0, 1, 1, 0);
      step(0, 16'hBEEF, 1, 0, 0, 1, 2, 0);
      step(1, 16'hBEEF, 1, 0, 0, 1, 0, 0);
      step(1, 16'h0000, 0, 0, 0, 1, 1, 0);
      // Wrap up then down on logical 3.
      step(1, 16'hFFFF, 4, 0, 0, 0, 0, 0);
      step(1, 16'h0000, 0, 5'b01000, 0, 4, 0, 0);
      step(1, 16'h0000, 0, 0, 0, 4, 4, 0);
      step(1, 16'h0000, 0, 0, 5'b01000, 4, 0, 0);
      step(1, 16'h0000, 0, 0, 0, 4, 0, 0);
      step(1, 16'h0000, 0, 0, 0, 0, 4, 0);
      // Load beats simultaneous inc and dec.
      step(1, 16'h1234, 2, 5'b00010, 5'b00010, 0, 0, 0);
      step(1, 16'h0000, 0, 0, 0, 2, 2, 0);
      // PCRA flip mapping.
      step(1, 16'h0100, 1, 0, 0, 0, 0, 0);
      step(1, 16'h8000, 2, 0, 0, 0, 0, 0);
      step(1, 16'h0000, 0, 0, 0, 0, 0, 1);
      step(1, 16'h0000, 0, 0, 0, 1, 2, 0);
      step(1, 16'h0000, 0, 5'b00001, 0, 0, 0, 0);
      step(1, 16'h0000, 0, 0, 0, 1, 2, 0);
      step(1, 16'h0000, 0, 5'b00001, 0, 1, 2, 1);
      step(1, 16'h0000, 0, 0, 0, 1, 2, 0);
      step(1, 16'h0000, 0, 0, 0, 0, 0, 1);
      step(1, 16'h0000, 0, 0, 0, 1, 2, 0);
      // Out-of-range selects, then asynchronous reset mid-sequence.
      step(1, 16'h0000, 7, 0, 0, 7, 0, 0);
      step(1, 16'h0000, 0, 5'b11111, 0, 6, 5, 1);
      step(0, 16'h5555, 3, 5'b11111, 0, 1, 2, 1);
      step(1, 16'h0000, 0, 0, 0, 1, 2, 0);

      for (int n = 0; n < 400; n++) begin
         case ($urandom_range(0, 4))
            0: xi = 16'hFFFF;
            1: xi = 16'h0000;
            2: xi = 16'hFFFE;
            3: xi = 16'h0001;
            default: xi = 16'($urandom);
         endcase
         step(($urandom_range(0, 60) != 0), xi,
              ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0,
              5'($urandom), 5'($urandom),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              ($urandom_range(0, 7) == 0));
      end

      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(negedge MAINCLK);
         waited++;
      end
      #3;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
